// File: rtl/memory_access_unit_pkg.sv
// Shared constants and types for the memory-stage access controller.
package memory_access_unit_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mau_state_t;

endpackage

// File: rtl/memory_access_unit_align.sv
// Combinational lane steering: store byte enables/replication, load extraction/extension,
// and the misaligned / illegal-funct3 fault flag.
module load_store_align
  import memory_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            addr_lo,
  input  logic [2:0]            funct3,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [3:0]            byte_en,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  fault
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = rdata[{addr_lo, 3'b000} +: 8];
  assign sel_half = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    byte_en   = '0;
    wdata     = '0;
    load_data = '0;
    fault     = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_SB: begin
          byte_en = 4'b0001 << addr_lo;
          wdata   = {4{store_data[7:0]}};
        end
        F3_SH: begin
          byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata   = {2{store_data[15:0]}};
          fault   = addr_lo[0];
        end
        F3_SW: begin
          byte_en = 4'b1111;
          wdata   = store_data;
          fault   = |addr_lo;
        end
        default: fault = 1'b1;
      endcase
    end else if (is_load) begin
      // Loads always fetch the whole word; lane selection happens on the way back.
      byte_en = 4'b1111;
      case (funct3)
        F3_LB:  load_data = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
        F3_LBU: load_data = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
        F3_LH: begin
          load_data = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
          fault     = addr_lo[0];
        end
        F3_LHU: begin
          load_data = {{(DATA_WIDTH-16){1'b0}}, sel_half};
          fault     = addr_lo[0];
        end
        F3_LW: begin
          load_data = rdata;
          fault     = |addr_lo;
        end
        default: fault = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/memory_access_unit.sv
// Memory-stage data-memory controller: issues one request per qualified load/store,
// stalls the pipeline until it completes, and returns aligned load data.
module memory_access_unit
  import memory_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   ALU_result_memory,
  input  logic [DATA_WIDTH-1:0]   store_data_memory,
  input  logic                    memRead_memory,
  input  logic                    memWrite_memory,
  input  logic [DATA_WIDTH-1:0]   instruction_memory,
  output logic                    dmem_req_valid,
  output logic                    dmem_req_write,
  output logic [ADDRESS_BITS-1:0] dmem_req_addr,
  output logic [DATA_WIDTH-1:0]   dmem_req_wdata,
  output logic [3:0]              dmem_req_byte_en,
  input  logic                    dmem_req_ready,
  input  logic                    dmem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   dmem_resp_rdata,
  output logic [DATA_WIDTH-1:0]   load_data_memory,
  output logic                    memory_stall,
  output logic                    access_fault_memory
);

  mau_state_t state_q, state_d;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic                  is_load, is_store, qualified, issue;
  logic                  al_fault;
  logic [3:0]            al_byte_en;
  logic [DATA_WIDTH-1:0] al_wdata, al_load_data;
  logic                  stall_c, fault_c;
  logic                  unused_bits;

  assign opcode    = instruction_memory[6:0];
  assign funct3    = instruction_memory[14:12];
  assign is_load   = (opcode == OP_LOAD)  && memRead_memory;
  assign is_store  = (opcode == OP_STORE) && memWrite_memory;
  assign qualified = is_load || is_store;
  assign issue     = qualified && !al_fault;

  assign unused_bits = ^{instruction_memory[DATA_WIDTH-1:15], instruction_memory[11:7],
                         ALU_result_memory[DATA_WIDTH-1:ADDRESS_BITS]};

  load_store_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .addr_lo    (ALU_result_memory[1:0]),
    .funct3     (funct3),
    .is_load    (is_load),
    .is_store   (is_store),
    .store_data (store_data_memory),
    .rdata      (dmem_resp_rdata),
    .byte_en    (al_byte_en),
    .wdata      (al_wdata),
    .load_data  (al_load_data),
    .fault      (al_fault)
  );

  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    fault_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          stall_c = 1'b1;
          state_d = REQ;
        end else if (qualified) begin
          fault_c = 1'b1;
        end
      end
      REQ: begin
        stall_c = 1'b1;
        if (dmem_req_ready) state_d = dmem_req_write ? DONE : WAIT;
      end
      WAIT: begin
        stall_c = 1'b1;
        if (dmem_resp_valid) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gated by reset so a mid-access reset releases the pipeline in the same cycle.
  assign memory_stall        = stall_c && !reset;
  assign access_fault_memory = fault_c && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      dmem_req_valid   <= 1'b0;
      dmem_req_write   <= 1'b0;
      dmem_req_addr    <= '0;
      dmem_req_wdata   <= '0;
      dmem_req_byte_en <= '0;
      load_data_memory <= '0;
    end else begin
      state_q        <= state_d;
      dmem_req_valid <= (state_d == REQ);
      if (state_q == IDLE && issue) begin
        dmem_req_write   <= is_store;
        dmem_req_addr    <= {ALU_result_memory[ADDRESS_BITS-1:2], 2'b00};
        dmem_req_wdata   <= al_wdata;
        dmem_req_byte_en <= al_byte_en;
      end
      // Address/funct3 are still held by the stall, so alignment uses live inputs.
      if (state_q == WAIT && dmem_resp_valid) load_data_memory <= al_load_data;
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: reset, NOP, loads, stores, faults, mid-access reset.
module tb_memory_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ALU_result_memory, store_data_memory, instruction_memory;
  logic        memRead_memory, memWrite_memory;
  logic        dmem_req_valid, dmem_req_write;
  logic [19:0] dmem_req_addr;
  logic [31:0] dmem_req_wdata;
  logic [3:0]  dmem_req_byte_en;
  logic        dmem_req_ready, dmem_resp_valid;
  logic [31:0] dmem_resp_rdata, load_data_memory;
  logic        memory_stall, access_fault_memory;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] LW  = 32'h0000_2003;
  localparam logic [31:0] LB  = 32'h0000_0003;
  localparam logic [31:0] LBU = 32'h0000_4003;
  localparam logic [31:0] LX3 = 32'h0000_3003;
  localparam logic [31:0] SH  = 32'h0000_1023;
  localparam logic [31:0] SB  = 32'h0000_0023;

  memory_access_unit dut (
    .clock(clock), .reset(reset),
    .ALU_result_memory(ALU_result_memory), .store_data_memory(store_data_memory),
    .memRead_memory(memRead_memory), .memWrite_memory(memWrite_memory),
    .instruction_memory(instruction_memory),
    .dmem_req_valid(dmem_req_valid), .dmem_req_write(dmem_req_write),
    .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata),
    .dmem_req_byte_en(dmem_req_byte_en), .dmem_req_ready(dmem_req_ready),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
    .load_data_memory(load_data_memory), .memory_stall(memory_stall),
    .access_fault_memory(access_fault_memory)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_nop();
    step();
    instruction_memory = NOP; memRead_memory = 1'b1; memWrite_memory = 1'b0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] instr, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    step();
    instruction_memory = instr; ALU_result_memory = addr; memRead_memory = 1'b1;
    #4 chk({tag, "_idle_stall"}, 32'(memory_stall), 32'd1);
    step(); dmem_req_ready = 1'b1;
    #4 chk({tag, "_req_valid"}, 32'(dmem_req_valid), 32'd1);
    chk({tag, "_req_addr"}, 32'(dmem_req_addr), addr & 32'hFFFF_FFFC);
    step(); dmem_req_ready = 1'b0; dmem_resp_valid = 1'b1; dmem_resp_rdata = rdata;
    #4 chk({tag, "_wait_stall"}, 32'(memory_stall), 32'd1);
    step(); dmem_resp_valid = 1'b0; dmem_resp_rdata = 32'h0;
    #4 chk({tag, "_done_stall"}, 32'(memory_stall), 32'd0);
    chk({tag, "_data"}, load_data_memory, exp);
  endtask

  initial begin
    reset = 1'b1;
    ALU_result_memory = 0; store_data_memory = 0; instruction_memory = NOP;
    memRead_memory = 0; memWrite_memory = 0;
    dmem_req_ready = 0; dmem_resp_valid = 0; dmem_resp_rdata = 0;

    // Reset values
    step(); step(); #4;
    chk("rst_valid", 32'(dmem_req_valid), 0);
    chk("rst_write", 32'(dmem_req_write), 0);
    chk("rst_stall", 32'(memory_stall), 0);
    chk("rst_fault", 32'(access_fault_memory), 0);
    chk("rst_addr", 32'(dmem_req_addr), 0);
    chk("rst_wdata", dmem_req_wdata, 0);
    chk("rst_be", 32'(dmem_req_byte_en), 0);
    chk("rst_ldata", load_data_memory, 0);

    // NOP with memRead set issues nothing
    step(); reset = 1'b0; memRead_memory = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #4 chk("nop_valid", 32'(dmem_req_valid), 0);
      chk("nop_stall", 32'(memory_stall), 0);
      step();
    end

    // LW 0x100: ready on first REQ cycle, response two cycles later
    instruction_memory = LW; ALU_result_memory = 32'h100;
    #4 chk("lw_idle_stall", 32'(memory_stall), 1);
    chk("lw_idle_valid", 32'(dmem_req_valid), 0);
    step(); dmem_req_ready = 1'b1;
    #4 chk("lw_req_valid", 32'(dmem_req_valid), 1);
    chk("lw_req_write", 32'(dmem_req_write), 0);
    chk("lw_req_addr", 32'(dmem_req_addr), 32'h100);
    chk("lw_req_be", 32'(dmem_req_byte_en), 32'hF);
    chk("lw_req_stall", 32'(memory_stall), 1);
    step(); dmem_req_ready = 1'b0;
    #4 chk("lw_wait1_stall", 32'(memory_stall), 1);
    chk("lw_wait1_valid", 32'(dmem_req_valid), 0);
    step(); dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'hDEAD_BEEF;
    #4 chk("lw_wait2_stall", 32'(memory_stall), 1);
    step(); dmem_resp_valid = 1'b0;
    #4 chk("lw_done_stall", 32'(memory_stall), 0);
    chk("lw_done_data", load_data_memory, 32'hDEAD_BEEF);
    idle_nop();
    #4 chk("lw_after_stall", 32'(memory_stall), 0);
    chk("lw_hold_data", load_data_memory, 32'hDEAD_BEEF);

    // Byte loads with sign/zero extension
    do_load("lb", LB, 32'h103, 32'h8011_2233, 32'hFFFF_FF80);
    idle_nop();
    do_load("lbu", LBU, 32'h103, 32'h8011_2233, 32'h0000_0080);
    idle_nop();

    // SH 0x202, ready held low three cycles
    step();
    instruction_memory = SH; memRead_memory = 1'b0; memWrite_memory = 1'b1;
    ALU_result_memory = 32'h202; store_data_memory = 32'h0000_ABCD;
    #4 chk("sh_idle_stall", 32'(memory_stall), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      #4 chk("sh_hold_valid", 32'(dmem_req_valid), 1);
      chk("sh_hold_write", 32'(dmem_req_write), 1);
      chk("sh_hold_addr", 32'(dmem_req_addr), 32'h200);
      chk("sh_hold_be", 32'(dmem_req_byte_en), 32'hC);
      chk("sh_hold_wdata", dmem_req_wdata, 32'hABCD_ABCD);
      chk("sh_hold_stall", 32'(memory_stall), 1);
    end
    step(); dmem_req_ready = 1'b1;
    #4 chk("sh_ready_stall", 32'(memory_stall), 1);
    chk("sh_ready_valid", 32'(dmem_req_valid), 1);
    step(); dmem_req_ready = 1'b0;
    #4 chk("sh_done_stall", 32'(memory_stall), 0);
    chk("sh_done_valid", 32'(dmem_req_valid), 0);
    chk("sh_ldata_kept", load_data_memory, 32'h0000_0080);
    idle_nop();

    // SB 0x201
    step();
    instruction_memory = SB; memRead_memory = 1'b0; memWrite_memory = 1'b1;
    ALU_result_memory = 32'h201; store_data_memory = 32'h1234_565A;
    #4 chk("sb_idle_stall", 32'(memory_stall), 1);
    step(); dmem_req_ready = 1'b1;
    #4 chk("sb_be", 32'(dmem_req_byte_en), 32'h2);
    chk("sb_wdata", dmem_req_wdata, 32'h5A5A_5A5A);
    chk("sb_addr", 32'(dmem_req_addr), 32'h200);
    chk("sb_write", 32'(dmem_req_write), 1);
    step(); dmem_req_ready = 1'b0;
    #4 chk("sb_done_stall", 32'(memory_stall), 0);
    idle_nop();

    // Misaligned LW: one-cycle fault, no request, no stall
    step(); instruction_memory = LW; ALU_result_memory = 32'h101;
    #4 chk("mis_fault", 32'(access_fault_memory), 1);
    chk("mis_stall", 32'(memory_stall), 0);
    chk("mis_valid", 32'(dmem_req_valid), 0);
    idle_nop();
    #4 chk("mis_fault_clr", 32'(access_fault_memory), 0);
    chk("mis_no_req", 32'(dmem_req_valid), 0);
    chk("mis_ldata_kept", load_data_memory, 32'h0000_0080);

    // Illegal load funct3
    step(); instruction_memory = LX3; ALU_result_memory = 32'h100;
    #4 chk("ill_fault", 32'(access_fault_memory), 1);
    chk("ill_stall", 32'(memory_stall), 0);
    idle_nop();
    #4 chk("ill_no_req", 32'(dmem_req_valid), 0);

    // Reset in WAIT; late response discarded
    step(); instruction_memory = LW; ALU_result_memory = 32'h100;
    #4 chk("rw_idle_stall", 32'(memory_stall), 1);
    step(); dmem_req_ready = 1'b1;
    #4 chk("rw_req_valid", 32'(dmem_req_valid), 1);
    step(); dmem_req_ready = 1'b0;
    #4 chk("rw_wait_stall", 32'(memory_stall), 1);
    #1 reset = 1'b1; instruction_memory = NOP;
    #1 chk("rw_rst_stall", 32'(memory_stall), 0);
    chk("rw_rst_valid", 32'(dmem_req_valid), 0);
    step(); reset = 1'b0; dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'h1234_5678;
    #4 chk("rw_resp_stall", 32'(memory_stall), 0);
    chk("rw_resp_valid", 32'(dmem_req_valid), 0);
    chk("rw_resp_ldata", load_data_memory, 0);
    step(); dmem_resp_valid = 1'b0;
    #4 chk("rw_after_ldata", load_data_memory, 0);
    chk("rw_after_stall", 32'(memory_stall), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
